// File: rtl/bouncing_box_renderer_pkg.sv
// Shared VGA pixel-stage definitions: default active area, box colours and the
// colour-state encoding used by the bouncing box renderer.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1920;
  localparam int unsigned V_ACTIVE_DEF = 1080;

  localparam logic [23:0] RED_RGB   = 24'hFF0000;
  localparam logic [23:0] GREEN_RGB = 24'h00FF00;
  localparam logic [23:0] BLUE_RGB  = 24'h0000FF;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_t;

  function automatic colour_t next_colour(input colour_t c);
    case (c)
      COL_RED:   next_colour = COL_GREEN;
      COL_GREEN: next_colour = COL_BLUE;
      COL_BLUE:  next_colour = COL_RED;
      default:   next_colour = COL_RED;
    endcase
  endfunction

  function automatic logic [23:0] colour_rgb(input colour_t c);
    case (c)
      COL_RED:   colour_rgb = RED_RGB;
      COL_GREEN: colour_rgb = GREEN_RGB;
      COL_BLUE:  colour_rgb = BLUE_RGB;
      default:   colour_rgb = RED_RGB;
    endcase
  endfunction

endpackage

// File: rtl/bouncing_box_renderer_box_motion_axis.sv
// One axis of box motion: moves pos by STEP per tick between 0 and LIM,
// reversing direction (and flagging a bounce) when a limit is reached or crossed.
module box_motion_axis #(
  parameter int LIM  = 1856,
  parameter int STEP = 4
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        tick,
  output logic [10:0] pos,
  output logic        bounce
);

  localparam logic [11:0] LIM12  = 12'(LIM);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [10:0] LIM11  = 11'(LIM);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic        dir_neg;
  logic        nxt_dir_neg;
  logic        hit;
  logic [11:0] pos_ext;
  logic [11:0] sum;
  logic [10:0] nxt_pos;

  // Next position/direction; limits are inclusive so landing on 0 or LIM bounces
  always_comb begin
    pos_ext     = {1'b0, pos};
    sum         = pos_ext + STEP12;
    nxt_pos     = pos;
    nxt_dir_neg = dir_neg;
    hit         = 1'b0;
    if (!dir_neg) begin
      if (sum >= LIM12) begin
        nxt_pos     = LIM11;
        nxt_dir_neg = 1'b1;
        hit         = 1'b1;
      end else begin
        nxt_pos = sum[10:0];
      end
    end else begin
      if (pos_ext <= STEP12) begin
        nxt_pos     = 11'd0;
        nxt_dir_neg = 1'b0;
        hit         = 1'b1;
      end else begin
        nxt_pos = pos - STEP11;
      end
    end
    bounce = tick & hit;
  end

  // Position and direction only change on the frame tick
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      pos     <= 11'd0;
      dir_neg <= 1'b0;
    end else if (tick) begin
      pos     <= nxt_pos;
      dir_neg <= nxt_dir_neg;
    end
  end

endmodule

// File: rtl/bouncing_box_renderer.sv
// Pixel-stage image source: a solid box bouncing over a flat background, advanced
// once per frame on the active v_sync edge; RGB and syncs leave with one cycle latency.
module bouncing_box_renderer
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          BOX_SIZE = 64,
  parameter int          STEP     = 4,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] BG_RGB   = 24'h101040
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        disp_ena,
  input  logic [10:0] row,
  input  logic [10:0] column,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        h_sync,
  output logic        v_sync,
  output logic        disp_ena_out
);

  localparam logic [11:0] BOX12 = 12'(BOX_SIZE);

  logic        v_sync_q;
  logic        tick;
  logic        bounce_x;
  logic        bounce_y;
  logic [10:0] box_x;
  logic [10:0] box_y;
  colour_t     colour;
  logic        in_box;
  logic [23:0] pix_rgb;

  assign tick = (v_sync_in == SYNC_POL) && (v_sync_q != SYNC_POL);

  box_motion_axis #(.LIM(H_ACTIVE - BOX_SIZE), .STEP(STEP)) u_axis_x (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .pos       (box_x),
    .bounce    (bounce_x)
  );

  box_motion_axis #(.LIM(V_ACTIVE - BOX_SIZE), .STEP(STEP)) u_axis_y (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .pos       (box_y),
    .bounce    (bounce_y)
  );

  // Colour advances one state per bouncing tick, even on a corner hit
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      colour <= COL_RED;
    end else if (tick && (bounce_x || bounce_y)) begin
      colour <= next_colour(colour);
    end
  end

  // Box hit test in 12 bits so box_pos + BOX_SIZE cannot wrap
  always_comb begin
    in_box = ({1'b0, column} >= {1'b0, box_x}) && ({1'b0, column} < ({1'b0, box_x} + BOX12)) &&
             ({1'b0, row}    >= {1'b0, box_y}) && ({1'b0, row}    < ({1'b0, box_y} + BOX12));
    if (!disp_ena) begin
      pix_rgb = 24'h000000;
    end else if (in_box) begin
      pix_rgb = colour_rgb(colour);
    end else begin
      pix_rgb = BG_RGB;
    end
  end

  // Output register stage; syncs share it so they stay aligned with RGB
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      red          <= 8'h00;
      green        <= 8'h00;
      blue         <= 8'h00;
      h_sync       <= ~SYNC_POL;
      v_sync       <= ~SYNC_POL;
      disp_ena_out <= 1'b0;
      v_sync_q     <= ~SYNC_POL;
    end else begin
      red          <= pix_rgb[23:16];
      green        <= pix_rgb[15:8];
      blue         <= pix_rgb[7:0];
      h_sync       <= h_sync_in;
      v_sync       <= v_sync_in;
      disp_ena_out <= disp_ena;
      v_sync_q     <= v_sync_in;
    end
  end

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Self-checking bench: three renderer instances (full HD, narrow 80-wide, 80x80)
// share randomized stimulus and are compared every cycle against a frame-level model.
module tb_bouncing_box_renderer;

  localparam logic [23:0] BG = 24'h101040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_ena;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [10:0] row;
  logic [10:0] column;

  logic [7:0] red_o   [3];
  logic [7:0] green_o [3];
  logic [7:0] blue_o  [3];
  logic       hs_o    [3];
  logic       vs_o    [3];
  logic       de_o    [3];

  int checks = 0;
  int errors = 0;

  // Model state: box corner, direction (+1/-1) and colour index per instance
  int limx [3] = '{1856, 16, 16};
  int limy [3] = '{1016, 1016, 16};
  int bx [3];
  int by [3];
  int dx [3];
  int dy [3];
  int ci [3];
  logic vq;
  logic [23:0] exp_rgb [3];
  logic exp_hs, exp_vs, exp_de;

  always #5 clk = ~clk;

  bouncing_box_renderer u_d0 (
    .pixel_clk(clk), .reset_n(reset_n), .disp_ena(disp_ena), .row(row), .column(column),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red(red_o[0]), .green(green_o[0]), .blue(blue_o[0]),
    .h_sync(hs_o[0]), .v_sync(vs_o[0]), .disp_ena_out(de_o[0]));

  bouncing_box_renderer #(.H_ACTIVE(80)) u_d1 (
    .pixel_clk(clk), .reset_n(reset_n), .disp_ena(disp_ena), .row(row), .column(column),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red(red_o[1]), .green(green_o[1]), .blue(blue_o[1]),
    .h_sync(hs_o[1]), .v_sync(vs_o[1]), .disp_ena_out(de_o[1]));

  bouncing_box_renderer #(.H_ACTIVE(80), .V_ACTIVE(80)) u_d2 (
    .pixel_clk(clk), .reset_n(reset_n), .disp_ena(disp_ena), .row(row), .column(column),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red(red_o[2]), .green(green_o[2]), .blue(blue_o[2]),
    .h_sync(hs_o[2]), .v_sync(vs_o[2]), .disp_ena_out(de_o[2]));

  function automatic logic [23:0] colour_of(input int c);
    case (c)
      0:       colour_of = 24'hFF0000;
      1:       colour_of = 24'h00FF00;
      2:       colour_of = 24'h0000FF;
      default: colour_of = 24'hXXXXXX;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one axis by one frame of motion, clamping to the wall and reversing
  task automatic move(inout int p, inout int d, input int lim, inout bit b);
    p = p + d * 4;
    if (d > 0 && p >= lim) begin
      p = lim; d = -1; b = 1'b1;
    end else if (d < 0 && p <= 0) begin
      p = 0; d = 1; b = 1'b1;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit b;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_rgb[i] = 24'h0;
        bx[i] = 0; by[i] = 0; dx[i] = 1; dy[i] = 1; ci[i] = 0;
      end
      exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; vq = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!disp_ena) exp_rgb[i] = 24'h0;
        else if (int'(column) >= bx[i] && int'(column) < bx[i] + 64 &&
                 int'(row) >= by[i] && int'(row) < by[i] + 64) exp_rgb[i] = colour_of(ci[i]);
        else exp_rgb[i] = BG;
      end
      exp_hs = h_sync_in; exp_vs = v_sync_in; exp_de = disp_ena;
      tick = (v_sync_in == 1'b0) && (vq == 1'b1);
      vq = v_sync_in;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          b = 1'b0;
          move(bx[i], dx[i], limx[i], b);
          move(by[i], dy[i], limy[i], b);
          if (b) ci[i] = (ci[i] + 1) % 3;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rgb%0d", i), {8'h0, red_o[i], green_o[i], blue_o[i]}, {8'h0, exp_rgb[i]});
      check($sformatf("h_sync%0d", i), {31'h0, hs_o[i]}, {31'h0, exp_hs});
      check($sformatf("v_sync%0d", i), {31'h0, vs_o[i]}, {31'h0, exp_vs});
      check($sformatf("de_out%0d", i), {31'h0, de_o[i]}, {31'h0, exp_de});
    end
  endtask

  task automatic cycle(input logic rn, input logic de, input logic hs, input logic vs,
                       input logic [10:0] r, input logic [10:0] c);
    reset_n = rn; disp_ena = de; h_sync_in = hs; v_sync_in = vs; row = r; column = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [10:0] rnd_coord();
    if ($urandom_range(0, 3) != 0) rnd_coord = 11'($urandom_range(0, 140));
    else rnd_coord = 11'($urandom_range(0, 2047));
  endfunction

  task automatic rand_cycle(input logic vs);
    cycle(1'b1, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), vs,
          rnd_coord(), rnd_coord());
  endtask

  task automatic pix(input logic [10:0] r, input logic [10:0] c);
    cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, r, c);
  endtask

  // One frame: active v_sync inactive for n cycles, then two active-low cycles
  task automatic frame(input int n);
    repeat (n) rand_cycle(1'b1);
    repeat (2) rand_cycle(1'b0);
    rand_cycle(1'b1);
  endtask

  function automatic logic [23:0] rgb(input int i);
    rgb = {red_o[i], green_o[i], blue_o[i]};
  endfunction

  initial begin
    repeat (3) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rnd_coord(), rnd_coord());
    check("reset_rgb", {8'h0, rgb(0)}, 32'h0);
    check("reset_hs", {31'h0, hs_o[0]}, 32'h1);
    check("reset_vs", {31'h0, vs_o[0]}, 32'h1);
    check("reset_de", {31'h0, de_o[0]}, 32'h0);

    pix(11'd10, 11'd10);
    check("lat_box", {8'h0, rgb(0)}, 32'hFF0000);
    pix(11'd10, 11'd64);
    check("lat_bg", {8'h0, rgb(0)}, 32'h101040);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 11'd10, 11'd10);
    check("lat_blank", {8'h0, rgb(0)}, 32'h0);

    repeat (3) frame($urandom_range(2, 6));
    check("model_x3", bx[0], 12);
    check("model_y3", by[0], 12);
    pix(11'd12, 11'd12);
    check("motion_in", {8'h0, rgb(0)}, 32'hFF0000);
    pix(11'd12, 11'd11);
    check("motion_bg", {8'h0, rgb(0)}, 32'h101040);
    check("model_c3", ci[1], 0);

    frame(3);
    check("xb_pos4", bx[1], 16);
    check("xb_col4", ci[1], 1);
    check("corner_col4", ci[2], 1);
    check("full_col4", ci[0], 0);
    pix(11'd16, 11'd16);
    check("xb_pix4", {8'h0, rgb(1)}, 32'h00FF00);
    check("corner_pix4", {8'h0, rgb(2)}, 32'h00FF00);

    frame(3);
    check("xb_pos5", bx[1], 12);
    check("xb_col5", ci[1], 1);
    check("corner_y5", by[2], 12);

    repeat (2) rand_cycle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 11'd5, 11'd5);
    pix(11'd0, 11'd0);
    check("midrst_box", {8'h0, rgb(0)}, 32'hFF0000);
    check("midrst_col1", {8'h0, rgb(1)}, 32'hFF0000);
    pix(11'd0, 11'd64);
    check("midrst_bg", {8'h0, rgb(0)}, 32'h101040);
    repeat (4) rand_cycle(1'b1);
    check("midrst_hold", bx[0], 0);

    for (int f = 0; f < 60; f++) begin
      frame($urandom_range(3, 25));
      if ($urandom_range(0, 29) == 0)
        cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_coord(), rnd_coord());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
